oam_dma_ram: RTL and testbench
==============================

OAM_DMA_RAM -- requirements
Module: oam_dma_ram

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, OAM address width; depth DEPTH = 2**ADDR_W.
REQ-002 SHALL have parameter DATA_W, default 8, OAM entry width.
REQ-003 SHALL have parameter DMA_LEN, default 256, bytes per DMA burst (1..DEPTH).
REQ-004 SHALL have parameter CLR_ON_RST, default 1, enabling the post-reset clear sweep.
REQ-005 SHALL have ports: clk in 1 system clock; rst_n in 1 asynchronous active-low reset.
REQ-006 SHALL have ports: clk_en in 1 PPU tick; all state advances only when clk_en=1.
REQ-007 SHALL have ports: addr_we in 1, addr_in in ADDR_W; load the CPU OAM pointer.
REQ-008 SHALL have ports: data_we in 1, data_in in DATA_W; CPU write to mem[ptr] with post-increment.
REQ-009 SHALL have ports: data_out out DATA_W; registered mem[ptr].
REQ-010 SHALL have ports: dma_start in 1, dma_page in 8; start a burst from CPU page dma_page.
REQ-011 SHALL have ports: dma_req out 1, dma_addr out 16; bus read request and address.
REQ-012 SHALL have ports: dma_rvalid in 1, dma_rdata in DATA_W; bus read return.
REQ-013 SHALL have ports: busy out 1 (clear or DMA active); dma_done out 1 (one-tick pulse).
REQ-014 SHALL have ports: ppu_addr in ADDR_W, ppu_data out DATA_W; PPU read port.

Function
REQ-015 SHALL implement FSM states CLEAR, IDLE, REQ, WAIT, WRITE, DONE.
REQ-016 CLEAR SHALL write 0 to mem[clr_cnt], clr_cnt 0..DEPTH-1, one entry per tick, then enter IDLE; when CLR_ON_RST=0 reset enters IDLE directly.
REQ-017 In IDLE, dma_start SHALL latch dma_page, zero byte count cnt, and enter REQ.
REQ-018 REQ SHALL assert dma_req with dma_addr={page,cnt[7:0]} for exactly one tick, then enter WAIT.
REQ-019 WAIT SHALL hold until dma_rvalid=1, capture dma_rdata, then enter WRITE; dma_addr stays stable during WAIT.
REQ-020 WRITE SHALL store the captured byte at mem[ptr], increment ptr modulo DEPTH, and increment cnt.
REQ-021 After WRITE, the FSM SHALL return to REQ if cnt<DMA_LEN; otherwise it SHALL enter DONE.
REQ-022 DONE SHALL pulse dma_done for one tick and return to IDLE.
REQ-023 DMA SHALL begin at the current ptr, not at 0; ptr wraps DEPTH-1 -> 0.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 dma_start outside IDLE SHALL be ignored.
REQ-026 data_we/addr_we SHALL take effect only in IDLE; ignored while busy.
REQ-027 addr_we and data_we in the same tick: addr_we SHALL win, ptr<=addr_in, and the data write is dropped.
REQ-028 data_we SHALL write mem[ptr], then ptr<=ptr+1 mod DEPTH.
REQ-029 data_out SHALL register mem[ptr] every enabled tick, giving a 1-tick latency after a ptr change.
REQ-030 ppu_data SHALL register mem[ppu_addr] every enabled tick with 1-tick latency; it is never blocked by busy.
REQ-031 Same-address PPU read and write in one tick SHALL return the old data.

Reset
REQ-032 On rst_n=0: state<=CLEAR (or IDLE if CLR_ON_RST=0), ptr=0, cnt=0, clr_cnt=0, dma_req=0, dma_done=0, data_out=0, ppu_data=0, dma_addr=0.
REQ-033 Reset mid-DMA SHALL abort the burst with no dma_done pulse; memory is re-cleared if CLR_ON_RST=1.

Structure
REQ-034 Shared package ppu_pkg SHALL hold the state enum oam_dma_state_t and OAM_DMA_LEN_DEFAULT.
REQ-035 Storage SHALL be a sub-module oam_dp_ram, with one write port and two synchronous read ports, replaceable by a synthesis macro.

Verification
REQ-036 Reset with CLR_ON_RST=1 -> busy=1 for 256 ticks; afterwards a read of every address returns 0.
REQ-037 addr_in=0xFE, then data_we with 0x11, 0x22, 0x33 -> mem[FE]=11, mem[FF]=22, mem[00]=33; ptr=0x01.
REQ-038 ptr=0x10, dma_start page 0x02, bus returns (addr&0xFF)^0x5A after 2-tick wait -> 256 dma_req pulses at 0x0200..0x02FF; mem[(0x10+i)&0xFF]=i^0x5A; one dma_done pulse.
REQ-039 data_we and dma_start during busy -> memory and ptr are unchanged by them; the burst completes normally.
REQ-040 addr_we(0x40) and data_we(0x99) in the same tick -> ptr=0x40 and mem[old ptr] is unchanged.
REQ-041 rst_n low at burst byte 100 -> dma_req=0 immediately; no dma_done pulse; CLEAR restarts.

Source files
------------

// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared PPU types and constants for the OAM DMA block
package ppu_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } oam_dma_state_t;

  localparam int OAM_DMA_LEN_DEFAULT = 256;

endpackage

// File: rtl/oam_dp_ram.sv
// rtl/oam_dp_ram.sv - OAM storage, one write port and two synchronous read ports
module oam_dp_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Array write; contents are not reset, the owner sweeps them clear.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered reads; a read of the address being written returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else if (en) begin
      rdata_a <= mem[raddr_a];
      rdata_b <= mem[raddr_b];
    end
  end

endmodule

// File: rtl/oam_dma_ram.sv
// rtl/oam_dma_ram.sv - sprite OAM with CPU pointer port, DMA burst engine and PPU read port
module oam_dma_ram
  import ppu_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int DMA_LEN    = OAM_DMA_LEN_DEFAULT,
  parameter int CLR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              addr_we,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              data_we,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic              dma_start,
  input  logic [7:0]        dma_page,
  output logic              dma_req,
  output logic [15:0]       dma_addr,
  input  logic              dma_rvalid,
  input  logic [DATA_W-1:0] dma_rdata,
  output logic              busy,
  output logic              dma_done,
  input  logic [ADDR_W-1:0] ppu_addr,
  output logic [DATA_W-1:0] ppu_data
);

  // The byte counter must reach DMA_LEN (up to DEPTH) and always supply 8 address bits.
  localparam int CNT_W = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;
  localparam oam_dma_state_t RST_STATE = (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

  oam_dma_state_t    state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] clr_cnt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [7:0]        page;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign cnt_inc = cnt + 1'b1;

  // State register; reset aborts any burst and restarts the clear sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
    end else if (clk_en) begin
      state <= state_nxt;
    end
  end

  // Next state, memory write port selection and status outputs.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_waddr = ptr;
    mem_wdata = data_in;
    case (state)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt;
        mem_wdata = '0;
        if (&clr_cnt) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        mem_we = data_we && !addr_we;
        if (dma_start) state_nxt = ST_REQ;
      end
      ST_REQ:   state_nxt = ST_WAIT;
      ST_WAIT:  if (dma_rvalid) state_nxt = ST_WRITE;
      ST_WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = rdata_q;
        state_nxt = (cnt_inc < CNT_W'(DMA_LEN)) ? ST_REQ : ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = RST_STATE;
    endcase
    if (!clk_en) mem_we = 1'b0;
    busy     = (state != ST_IDLE);
    dma_req  = (state == ST_REQ);
    dma_done = (state == ST_DONE);
    dma_addr = {page, cnt[7:0]};
  end

  // Pointer, byte counter, clear counter, burst page and captured bus byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      cnt     <= '0;
      clr_cnt <= '0;
      page    <= '0;
      rdata_q <= '0;
    end else if (clk_en) begin
      case (state)
        ST_CLEAR: clr_cnt <= clr_cnt + 1'b1;
        ST_IDLE: begin
          if (addr_we) begin
            ptr <= addr_in;
          end else if (data_we) begin
            ptr <= ptr + 1'b1;
          end
          if (dma_start) begin
            page <= dma_page;
            cnt  <= '0;
          end
        end
        ST_WAIT:  if (dma_rvalid) rdata_q <= dma_rdata;
        ST_WRITE: begin
          ptr <= ptr + 1'b1;
          cnt <= cnt_inc;
        end
        default: ;
      endcase
    end
  end

  oam_dp_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (clk_en),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .raddr_a (ptr),
    .rdata_a (data_out),
    .raddr_b (ppu_addr),
    .rdata_b (ppu_data)
  );

endmodule

// File: tb/tb_oam_dma_ram.sv
// tb/tb_oam_dma_ram.sv - directed self-checking bench for oam_dma_ram
module tb_oam_dma_ram;

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic        addr_we;
  logic [7:0]  addr_in;
  logic        data_we;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        dma_start;
  logic [7:0]  dma_page;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic        dma_rvalid;
  logic [7:0]  dma_rdata;
  logic        busy;
  logic        dma_done;
  logic [7:0]  ppu_addr;
  logic [7:0]  ppu_data;

  int n_checks;
  int n_fail;
  int req_cnt;
  int done_cnt;
  int addr_err;
  logic [15:0] bus_base;

  oam_dma_ram dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .addr_we    (addr_we),
    .addr_in    (addr_in),
    .data_we    (data_we),
    .data_in    (data_in),
    .data_out   (data_out),
    .dma_start  (dma_start),
    .dma_page   (dma_page),
    .dma_req    (dma_req),
    .dma_addr   (dma_addr),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .busy       (busy),
    .dma_done   (dma_done),
    .ppu_addr   (ppu_addr),
    .ppu_data   (ppu_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ppu_read(input logic [7:0] a, output logic [7:0] d);
    ppu_addr = a;
    tick();
    d = ppu_data;
  endtask

  task automatic set_ptr(input logic [7:0] a);
    addr_we = 1'b1;
    addr_in = a;
    tick();
    addr_we = 1'b0;
  endtask

  task automatic cpu_write(input logic [7:0] d);
    data_we = 1'b1;
    data_in = d;
    tick();
    data_we = 1'b0;
  endtask

  task automatic count_clear(output int n);
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic count_nonzero(output int bad);
    logic [7:0] d;
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      ppu_read(8'(a), d);
      if (d !== 8'h00) bad++;
    end
  endtask

  // Bus model: answers every request after two wait ticks with (addr & 0xFF) ^ 0x5A.
  initial begin
    logic [15:0] a_l;
    dma_rvalid = 1'b0;
    dma_rdata  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (dma_req) begin
        a_l = dma_addr;
        if (a_l !== bus_base + 16'(req_cnt)) addr_err++;
        req_cnt++;
        @(posedge clk);
        #1;
        if (dma_addr !== a_l) addr_err++;
        @(posedge clk);
        #1;
        if (dma_addr !== a_l) addr_err++;
        dma_rvalid = 1'b1;
        dma_rdata  = a_l[7:0] ^ 8'h5A;
        @(posedge clk);
        #1;
        dma_rvalid = 1'b0;
      end
    end
  end

  // Counts ticks on which dma_done is high.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (dma_done) done_cnt++;
    end
  end

  initial begin
    int n;
    int bad;
    logic [7:0] d;

    n_checks  = 0;
    n_fail    = 0;
    req_cnt   = 0;
    done_cnt  = 0;
    addr_err  = 0;
    bus_base  = 16'h0200;
    rst_n     = 1'b0;
    clk_en    = 1'b1;
    addr_we   = 1'b0;
    addr_in   = 8'h00;
    data_we   = 1'b0;
    data_in   = 8'h00;
    dma_start = 1'b0;
    dma_page  = 8'h00;
    ppu_addr  = 8'h00;

    #3;
    check("rst_busy", busy, 1);
    check("rst_dma_req", dma_req, 0);
    check("rst_dma_done", dma_done, 0);
    check("rst_dma_addr", dma_addr, 16'h0000);
    check("rst_data_out", data_out, 8'h00);
    check("rst_ppu_data", ppu_data, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;

    count_clear(n);
    check("clear_ticks", n, 256);
    count_nonzero(bad);
    check("clear_all_zero", bad, 0);

    // CPU pointer writes wrapping across the top of OAM.
    set_ptr(8'hFE);
    cpu_write(8'h11);
    cpu_write(8'h22);
    cpu_write(8'h33);
    cpu_write(8'h44);
    ppu_read(8'hFE, d); check("cpu_mem_fe", d, 8'h11);
    ppu_read(8'hFF, d); check("cpu_mem_ff", d, 8'h22);
    ppu_read(8'h00, d); check("cpu_mem_00", d, 8'h33);
    ppu_read(8'h01, d); check("cpu_ptr_was_01", d, 8'h44);
    ppu_read(8'h02, d); check("cpu_mem_02", d, 8'h00);

    // data_out follows ptr one tick late.
    set_ptr(8'hFE);
    check("data_out_lag", data_out, 8'h00);
    tick();
    check("data_out_fe", data_out, 8'h11);

    // Same-address PPU read during a write sees the old byte.
    set_ptr(8'h05);
    ppu_addr = 8'h05;
    cpu_write(8'h77);
    check("ppu_old_data", ppu_data, 8'h00);
    tick();
    check("ppu_new_data", ppu_data, 8'h77);

    // addr_we beats data_we in the same tick.
    addr_we = 1'b1;
    addr_in = 8'h40;
    data_we = 1'b1;
    data_in = 8'h99;
    tick();
    addr_we = 1'b0;
    data_we = 1'b0;
    ppu_read(8'h06, d); check("addr_wins_old_ptr", d, 8'h00);
    cpu_write(8'hAB);
    ppu_read(8'h40, d); check("addr_wins_new_ptr", d, 8'hAB);

    // Nothing advances while clk_en is low.
    clk_en   = 1'b0;
    ppu_addr = 8'hFE;
    cpu_write(8'hEE);
    check("clk_en_hold_ppu", ppu_data, 8'hAB);
    clk_en = 1'b1;
    cpu_write(8'hCD);
    ppu_read(8'h41, d); check("clk_en_no_write", d, 8'hCD);
    ppu_read(8'h42, d); check("clk_en_no_ptr", d, 8'h00);

    // Full burst from page 0x02 starting at ptr 0x10, with ignored CPU activity mid-burst.
    set_ptr(8'h10);
    req_cnt   = 0;
    done_cnt  = 0;
    addr_err  = 0;
    bus_base  = 16'h0200;
    dma_start = 1'b1;
    dma_page  = 8'h02;
    tick();
    dma_start = 1'b0;
    check("dma_busy", busy, 1);
    repeat (20) tick();
    data_we   = 1'b1;
    data_in   = 8'hEE;
    addr_we   = 1'b1;
    addr_in   = 8'h80;
    dma_start = 1'b1;
    dma_page  = 8'h07;
    tick();
    data_we   = 1'b0;
    addr_we   = 1'b0;
    dma_start = 1'b0;
    n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    check("dma_finished", busy, 0);
    check("dma_req_count", req_cnt, 256);
    check("dma_addr_errors", addr_err, 0);
    check("dma_done_pulses", done_cnt, 1);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      ppu_read(8'((16 + i) & 255), d);
      if (d !== (8'(i) ^ 8'h5A)) bad++;
    end
    check("dma_mem_errors", bad, 0);
    ppu_read(8'h0F, d); check("dma_mem_0f", d, 8'hA5);
    tick();
    check("dma_ptr_wrapped", data_out, 8'h5A);

    // Reset in the middle of a burst.
    set_ptr(8'h00);
    req_cnt   = 0;
    done_cnt  = 0;
    addr_err  = 0;
    bus_base  = 16'h0300;
    dma_start = 1'b1;
    dma_page  = 8'h03;
    tick();
    dma_start = 1'b0;
    n = 0;
    while (req_cnt < 101 && n < 2000) begin
      tick();
      n++;
    end
    check("abort_reached_100", req_cnt, 101);
    check("abort_req_before", dma_req, 1);
    rst_n = 1'b0;
    #1;
    check("abort_req_low", dma_req, 0);
    check("abort_busy", busy, 1);
    check("abort_dma_addr", dma_addr, 16'h0000);
    tick();
    tick();
    rst_n = 1'b1;
    count_clear(n);
    check("abort_clear_ticks", n, 256);
    check("abort_no_done", done_cnt, 0);
    count_nonzero(bad);
    check("abort_reclear", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
